// File: rtl/ca_pipe_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and default widths.
package ca_pipe_pkg;

  // Default widths of the multi-cycle latency field and perf counter.
  localparam int unsigned CNT_W_DEF  = 6;
  localparam int unsigned PERF_W_DEF = 16;

  // Stage FSM encoding, fixed so other stages and debug views agree on it.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StExec = EXEC,
    StDone = DONE
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Shared by the per-stage perf counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_max;

  assign at_max = (count_q == {W{1'b1}});

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ex1_stage_ctrl.sv
// EX1 -> ME1 transfer controller: ACT strobe, ME1 bubble mask, multi-cycle hold,
// ID stall, flush kill and a saturating EX1 stall-cycle counter.
module ex1_stage_ctrl
  import ca_pipe_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PERF_W = PERF_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex1_valid,
  input  logic              ex1_mc,
  input  logic [CNT_W-1:0]  ex1_mc_lat,
  input  logic              me1_ready,
  input  logic              flush,
  input  logic              perf_clr,
  output logic              ex1_act,
  output logic              me1_valid_mask,
  output logic              ex1_stall,
  output logic              mc_start,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  localparam logic [CNT_W-1:0] LAT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAT_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] LAT_THREE = CNT_W'(3);

  stage_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A multi-cycle op needs at least two EX1 cycles; 0 and 1 behave as single-cycle.
  logic mc_entry;
  assign mc_entry = ex1_valid && ex1_mc && (ex1_mc_lat >= LAT_TWO);

  // Next state, latency counter and combinational stage outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    me1_valid_mask = 1'b0;
    ex1_stall      = 1'b0;
    mc_start       = 1'b0;
    // ME1 advances whenever ready; the mask decides instruction or bubble.
    ex1_act        = me1_ready & ~RST;

    unique case (state_q)
      StIdle: begin
        if (mc_entry) begin
          mc_start  = 1'b1;
          ex1_stall = 1'b1;
          // Entry cycle and handoff cycle are not counted, hence lat - 2.
          cnt_d     = ex1_mc_lat - LAT_TWO;
          state_d   = (ex1_mc_lat >= LAT_THREE) ? StExec : StDone;
        end else if (ex1_valid) begin
          me1_valid_mask = me1_ready;
          ex1_stall      = ~me1_ready;
        end
      end
      StExec: begin
        ex1_stall = 1'b1;
        cnt_d     = cnt_q - LAT_ONE;
        // Decision on the pre-decrement value; <= also guards a stray zero.
        if (cnt_q <= LAT_ONE) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (me1_ready) begin
          me1_valid_mask = 1'b1;
          state_d        = StIdle;
        end else begin
          ex1_stall = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Flush and reset kill the EX1 op this cycle and return to idle.
    if (flush || RST) begin
      me1_valid_mask = 1'b0;
      ex1_stall      = 1'b0;
      mc_start       = 1'b0;
      state_d        = StIdle;
      cnt_d          = '0;
    end
  end

  // FSM state and latency down-counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall-cycle perf counter; reset clears it like perf_clr does.
  sat_counter #(
    .W (PERF_W)
  ) u_perf_cnt (
    .clk   (CLK),
    .clr   (RST | perf_clr),
    .inc   (ex1_stall),
    .count (perf_stall_cnt)
  );

endmodule

// File: tb/tb_ex1_stage_ctrl.sv
// Directed bench for ex1_stage_ctrl with a narrow perf counter to reach saturation.
module tb_ex1_stage_ctrl;

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PERF_W = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              ex1_valid;
  logic              ex1_mc;
  logic [CNT_W-1:0]  ex1_mc_lat;
  logic              me1_ready;
  logic              flush;
  logic              perf_clr;
  logic              ex1_act;
  logic              me1_valid_mask;
  logic              ex1_stall;
  logic              mc_start;
  logic [PERF_W-1:0] perf_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ex1_stage_ctrl #(
    .CNT_W  (CNT_W),
    .PERF_W (PERF_W)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ex1_valid      (ex1_valid),
    .ex1_mc         (ex1_mc),
    .ex1_mc_lat     (ex1_mc_lat),
    .me1_ready      (me1_ready),
    .flush          (flush),
    .perf_clr       (perf_clr),
    .ex1_act        (ex1_act),
    .me1_valid_mask (me1_valid_mask),
    .ex1_stall      (ex1_stall),
    .mc_start       (mc_start),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic a, input logic m, input logic s,
                         input logic st);
    chk({tag, ".act"},   16'(ex1_act),        16'(a));
    chk({tag, ".mask"},  16'(me1_valid_mask), 16'(m));
    chk({tag, ".stall"}, 16'(ex1_stall),      16'(s));
    chk({tag, ".start"}, 16'(mc_start),       16'(st));
  endtask

  task automatic chk_perf(input string tag, input int exp);
    chk({tag, ".perf"}, 16'(perf_stall_cnt), 16'(exp));
  endtask

  // Advance to the next cycle (drive on negedge, sample 1 time unit later).
  task automatic step(input logic rst, input logic v, input logic mc, input int lat,
                      input logic rdy, input logic fl, input logic clr);
    @(negedge CLK);
    RST        = rst;
    ex1_valid  = v;
    ex1_mc     = mc;
    ex1_mc_lat = CNT_W'(lat);
    me1_ready  = rdy;
    flush      = fl;
    perf_clr   = clr;
    #1;
  endtask

  initial begin
    RST = 1'b1; ex1_valid = 1'b1; ex1_mc = 1'b1; ex1_mc_lat = CNT_W'(4);
    me1_ready = 1'b1; flush = 1'b0; perf_clr = 1'b0;

    // Reset: all strobes low even with a pending mc op and ME1 ready.
    step(1, 1, 1, 4, 1, 0, 0);
    chk_out("rst", 0, 0, 0, 0);
    chk_perf("rst", 0);

    // Single-cycle op with ME1 stalled for two cycles.
    step(0, 1, 0, 0, 0, 0, 0);  chk_out("sc0", 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0);  chk_out("sc1", 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 0);  chk_out("sc2", 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);  chk_out("sc3", 0, 0, 0, 0);
    chk_perf("sc3", 2);

    // Multi-cycle L=4; lat change mid-op must be ignored.
    step(0, 1, 1, 4, 1, 0, 0);  chk_out("l4c0", 1, 0, 1, 1);
    step(0, 1, 1, 2, 1, 0, 0);  chk_out("l4c1", 1, 0, 1, 0);
    step(0, 1, 1, 2, 1, 0, 0);  chk_out("l4c2", 1, 0, 1, 0);
    step(0, 1, 1, 2, 1, 0, 0);  chk_out("l4c3", 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);  chk_out("l4c4", 1, 0, 0, 0);
    chk_perf("l4c4", 5);

    // L=2 with DONE wait, then a back-to-back L=3 op right after handoff.
    step(0, 1, 1, 2, 1, 0, 0);  chk_out("l2c0", 1, 0, 1, 1);
    step(0, 1, 1, 2, 0, 0, 0);  chk_out("l2c1", 0, 0, 1, 0);
    step(0, 1, 1, 2, 0, 0, 0);  chk_out("l2c2", 0, 0, 1, 0);
    step(0, 1, 1, 2, 1, 0, 0);  chk_out("l2c3", 1, 1, 0, 0);
    step(0, 1, 1, 3, 1, 0, 0);  chk_out("l3c0", 1, 0, 1, 1);
    step(0, 1, 1, 3, 1, 0, 0);  chk_out("l3c1", 1, 0, 1, 0);
    step(0, 1, 1, 3, 1, 0, 0);  chk_out("l3c2", 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);  chk_out("l3c3", 1, 0, 0, 0);
    chk_perf("l3c3", 10);

    // Flush in EXEC of an L=8 op; no late commit afterwards.
    step(0, 1, 1, 8, 1, 0, 0);  chk_out("fl0", 1, 0, 1, 1);
    step(0, 1, 1, 8, 1, 0, 0);  chk_out("fl1", 1, 0, 1, 0);
    step(0, 1, 1, 8, 1, 0, 0);  chk_out("fl2", 1, 0, 1, 0);
    step(0, 1, 1, 8, 1, 1, 0);  chk_out("fl3", 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);  chk_out("fl4", 1, 0, 0, 0);
    chk_perf("fl4", 13);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      chk("fl_late.mask", 16'(me1_valid_mask), 16'd0);
    end

    // Flush coinciding with mc entry: no start, stays idle.
    step(0, 1, 1, 5, 1, 1, 0);  chk_out("fle0", 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);  chk_out("fle1", 1, 0, 0, 0);
    chk_perf("fle1", 13);

    // mc with lat 0 / 1 behaves as single-cycle.
    step(0, 1, 1, 0, 1, 0, 0);  chk_out("lat0", 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);  chk_out("lat1a", 0, 0, 1, 0);
    step(0, 1, 1, 1, 1, 0, 0);  chk_out("lat1b", 1, 1, 0, 0);

    // Perf saturation at 15, then clear while stalling.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      if (i == 0) chk_perf("sat_start", 14);
    end
    step(0, 1, 0, 0, 0, 0, 1);
    chk_perf("sat_hold", 15);
    chk("sat_clr.stall", 16'(ex1_stall), 16'd1);
    step(0, 1, 0, 0, 0, 0, 0);  chk_perf("clr0", 0);
    step(0, 1, 0, 0, 1, 0, 0);  chk_perf("clr1", 1);
    chk_out("clr1", 1, 1, 0, 0);

    // Reset mid-EXEC abandons the op and clears perf.
    step(0, 1, 1, 8, 1, 0, 0);  chk_out("rx0", 1, 0, 1, 1);
    step(0, 1, 1, 8, 1, 0, 0);  chk_out("rx1", 1, 0, 1, 0);
    step(1, 1, 1, 8, 1, 0, 0);  chk_out("rx2", 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);  chk_out("rx3", 1, 0, 0, 0);
    chk_perf("rx3", 0);
    step(0, 1, 0, 0, 1, 0, 0);  chk_out("rx4", 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
